// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the shared 512 B byte memory.
// Data port wins unless the burst counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_done,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_funct3_q, mem_funct3_d;
    logic              d_ill_q, d_ill_d;
    logic              d_store_q, d_store_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              d_err_q, d_err_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_legal;
    logic              d_win;
    logic [1:0]        if_addr_unused;

    // Fetches are always word-aligned; the low address bits carry nothing.
    assign if_addr_unused = if_addr[1:0];

    // Classify the presented data access as servable by memory or not
    always_comb begin
        d_legal = 1'b0;
        unique case (d_funct3)
            3'b000:  d_legal = 1'b1;
            3'b001:  d_legal = ~d_addr[0];
            3'b010:  d_legal = (d_addr[1:0] == 2'b00);
            default: d_legal = 1'b0;
        endcase
    end

    // Pick the winner, latch its fields, track the burst, retire the last grant
    always_comb begin
        state_d      = IDLE;
        burst_d      = burst_q;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_funct3_d = mem_funct3_q;
        d_ill_d      = d_ill_q;
        d_store_d    = d_store_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        d_win = d_req && (!if_req || (burst_q < BURST_MAX));

        if (d_win) begin
            state_d      = GNT_D;
            d_gnt_d      = 1'b1;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
            mem_funct3_d = d_funct3;
            mem_read_d   = d_legal & ~d_we;
            mem_write_d  = d_legal & d_we;
            d_ill_d      = ~d_legal;
            d_store_d    = d_we;
        end else if (if_req) begin
            state_d      = GNT_IF;
            if_gnt_d     = 1'b1;
            mem_addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
            mem_funct3_d = 3'b010;
            mem_read_d   = 1'b1;
        end

        // Count data grants only while a fetch is being held off
        if (!if_req || !d_win) begin
            burst_d = 4'd0;
        end else if (burst_q < BURST_MAX) begin
            burst_d = burst_q + 4'd1;
        end

        if (state_q == GNT_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
        end else if (state_q == GNT_D) begin
            d_done_d = 1'b1;
            if (d_ill_q) begin
                d_err_d   = 1'b1;
                d_rdata_d = 32'd0;
            end else if (!d_store_q) begin
                d_rdata_d = mem_rdata;
            end
        end
    end

    // Grant-stage and response registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            burst_q      <= 4'd0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_funct3_q <= 3'd0;
            d_ill_q      <= 1'b0;
            d_store_q    <= 1'b0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_funct3_q <= mem_funct3_d;
            d_ill_q      <= d_ill_d;
            d_store_q    <= d_store_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_gnt     = if_gnt_q;
    assign if_done    = if_done_q;
    assign if_rdata   = if_rdata_q;
    assign d_gnt      = d_gnt_q;
    assign d_done     = d_done_q;
    assign d_err      = d_err_q;
    assign d_rdata    = d_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single byte-addressed memory (512 B, shared instruction/data) between the instruction-fetch port and the load/store data port.
- Registers one request per cycle into a grant stage and drives the memory's read/write/funct3/address lines from that register.
- Captures read data into per-port response registers.
- Data port has priority. A burst counter guarantees fetch progress. Misaligned or unsupported data accesses get an error response and never reach memory.

Parameters:
- ADDR_W, 9, byte address width of memory.
- MAX_D_BURST, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock; all state changes on posedge (memory itself writes on negedge)
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request (level); fields stable until if_gnt seen
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (forced 00)
- if_gnt  out  1  high for exactly the grant cycle of a fetch
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request (level)
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_funct3  in  3  000 byte, 001 half, 010 word; others unsupported
- d_gnt  out  1  high for exactly the grant cycle of a data access
- d_done  out  1  one-cycle completion pulse (loads and stores)
- d_err  out  1  qualifies d_done: access rejected
- d_rdata  out  32  load data
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  32  to memory data_in
- mem_funct3  out  3  to memory funct3
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  32  from memory data_out (combinational)

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; burst counter 0. Reset mid-grant aborts the access: mem_write drops at once (no negedge write), and no done is issued.
- States: IDLE, GNT_IF, GNT_D. From any state, at each posedge:
  - if d_req and (if_req=0 or burst<MAX_D_BURST) -> GNT_D;
  - else if if_req -> GNT_IF;
  - else -> IDLE.
- Sampling: requests present at the posedge are accepted and their fields latched into the grant register.
- Back-to-back: a requester sees gnt during the grant cycle and must update or drop req before the next edge. Throughput is one access per cycle.
- Burst counter:
  - increments on each data grant while if_req=1;
  - clears on a fetch grant or whenever if_req=0;
  - saturates at MAX_D_BURST.
- GNT_IF cycle: mem_read=1, mem_write=0, mem_funct3=010, mem_addr={if_addr[ADDR_W-1:2],2'b00}, if_gnt=1.
- GNT_D cycle, legal access:
  - mem_read=~d_we, mem_write=d_we, mem_funct3/addr/wdata from the latch;
  - d_gnt=1.
- Legality:
  - 001 requires addr[0]=0;
  - 010 requires addr[1:0]=00;
  - funct3 values 011..111 are illegal.
- GNT_D cycle, illegal access: d_gnt=1, mem_read=mem_write=0.
- Outside grant cycles: mem_read=mem_write=0; mem_addr/wdata/funct3 hold their last value.
- Completion: on the posedge ending a grant cycle, the port's done pulses for one cycle.
  - Fetch or legal load: rdata <= mem_rdata.
  - Store: rdata unchanged, d_err=0.
  - Illegal access: d_rdata <= 0, d_err=1.
  - d_err is 0 whenever d_done=0.
- Latency: req sampled at edge k -> gnt in cycle k..k+1 -> done and rdata in cycle k+1..k+2. The store's memory write lands at the negedge inside the grant cycle.
- Simultaneous requests: data wins unless burst=MAX_D_BURST. The losing request stays pending; there is no gnt for it.
- rdata registers hold their value between completions.

Test Plan:
- Reset asserted mid-GNT_D store (d_addr=0x100, d_wdata=0xDEADBEEF, funct3=010) -> mem_write falls immediately, no d_done, mem[0x100..0x103] unchanged; all outputs 0.
- Single fetch if_addr=0x012 -> mem_addr=0x010, mem_funct3=010, if_gnt in cycle 1, if_done with if_rdata = word at 0x010 in cycle 2.
- Word load d_addr=0x190 after preload bytes 05,69,2E,16 -> d_done, d_rdata=0x162E6905, d_err=0.
- Store byte 0xAB at 0x1A0, then load half at 0x1A0 back-to-back -> consecutive d_gnt cycles; load returns 0x0000xxAB with the low byte 0xAB.
- Both req held continuously, MAX_D_BURST=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Word load at d_addr=0x191 and funct3=011 -> d_gnt, mem_read=0, d_done with d_err=1, d_rdata=0.
